// File: rtl/alu_unit.sv
// Registered 16-bit execute-stage ALU: decode, datapath result, PSR flags and flag write enable.
// Optional multiplier is built only when ALU_MUL_EN is defined; otherwise MUL/MULI return zero.
module alu_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dst,
    input  logic [15:0] src,
    input  logic [3:0]  oper,
    input  logic [3:0]  func,
    input  logic [3:0]  cond,
    input  logic [4:0]  condIn,
    output logic [15:0] result,
    output logic [4:0]  condOut,
    output logic        condWr
);

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_SPEC  = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_ADDUI = 4'h6;
    localparam logic [3:0] OP_ADDCI = 4'h7;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_SUBCI = 4'hA;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_MULI  = 4'hE;
    localparam logic [3:0] OP_LUI   = 4'hF;

    // PSR ordering is {C,L,F,Z,N}
    function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] psr);
        logic c, l, f, z, n;
        c = psr[4];
        l = psr[3];
        f = psr[2];
        z = psr[1];
        n = psr[0];
        case (cc)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return l;
            4'd5:    return !l;
            4'd6:    return n;
            4'd7:    return !n;
            4'd8:    return f;
            4'd9:    return !f;
            4'd10:   return !l && !z;
            4'd11:   return l || z;
            4'd12:   return !n && !z;
            4'd13:   return n || z;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] shr_logic(input logic [15:0] v, input logic [4:0] amt);
        if (amt[4]) begin
            return 16'h0000;
        end else begin
            return v >> amt[3:0];
        end
    endfunction

    function automatic logic [15:0] shr_arith(input logic [15:0] v, input logic [4:0] amt);
        if (amt[4]) begin
            return {16{v[15]}};
        end else begin
            return $unsigned($signed(v) >>> amt[3:0]);
        end
    endfunction

    logic        reg_op_s, add_fl_s, sub_fl_s, cmp_s, logic_wr_s, use_cin_s, cin_s, taken_s;
    logic        add_ovf_s, sub_ovf_s, wr_s, c_s, l_s, f_s, z_s, n_s;
    logic [16:0] sum_s, diff_s;
    logic [15:0] mul_s, shl_s, shift_res_s;
    logic [4:0]  amt_s;
    logic [15:0] result_d, result_q;
    logic [4:0]  cond_out_d, cond_out_q;
    logic        cond_wr_d, cond_wr_q;

    // Operation classification, shared arithmetic and condition evaluation
    always_comb begin
        reg_op_s   = (oper == OP_REG);
        add_fl_s   = (oper == OP_ADDI) || (oper == OP_ADDCI) ||
                     (reg_op_s && ((func == 4'h5) || (func == 4'h7)));
        sub_fl_s   = (oper == OP_SUBI) || (oper == OP_SUBCI) ||
                     (reg_op_s && ((func == 4'h9) || (func == 4'hA)));
        cmp_s      = (oper == OP_CMPI) || (reg_op_s && (func == 4'hB));
        logic_wr_s = (oper == OP_ANDI) || (oper == OP_ORI) || (oper == OP_XORI) ||
                     (reg_op_s && ((func == 4'h1) || (func == 4'h2) || (func == 4'h3) ||
                                   (func == 4'h4) || (func == 4'hF)));
        use_cin_s  = (oper == OP_ADDCI) || (oper == OP_SUBCI) ||
                     (reg_op_s && ((func == 4'h7) || (func == 4'hA)));
        cin_s      = use_cin_s & condIn[4];
        sum_s      = {1'b0, dst} + {1'b0, src} + {16'h0000, cin_s};
        diff_s     = {1'b0, dst} - {1'b0, src} - {16'h0000, cin_s};
        add_ovf_s  = (dst[15] == src[15]) && (sum_s[15] != dst[15]);
        sub_ovf_s  = (dst[15] != src[15]) && (diff_s[15] != dst[15]);
        taken_s    = cond_eval(cond, condIn);
        // Right shifts encode their amount as a negative count
        amt_s      = 5'd0 - src[4:0];
        shl_s      = dst << src[3:0];
`ifdef ALU_MUL_EN
        mul_s      = dst * src;
`else
        mul_s      = 16'h0000;
`endif
    end

    // Shift unit
    always_comb begin
        shift_res_s = sum_s[15:0];
        case (func)
            4'h0, 4'h2: shift_res_s = shl_s;
            4'h1:       shift_res_s = shr_logic(dst, amt_s);
            4'h3:       shift_res_s = shr_arith(dst, amt_s);
            4'h4:       shift_res_s = src[15] ? shr_logic(dst, amt_s) : shl_s;
            4'h6:       shift_res_s = src[15] ? shr_arith(dst, amt_s) : shl_s;
            default:    shift_res_s = sum_s[15:0];
        endcase
    end

    // Result select
    always_comb begin
        result_d = 16'h0000;
        case (oper)
            OP_REG: begin
                case (func)
                    4'h1, 4'hF:       result_d = dst & src;
                    4'h2:             result_d = dst | src;
                    4'h3:             result_d = dst ^ src;
                    4'h4:             result_d = ~dst;
                    4'h9, 4'hA, 4'hB: result_d = diff_s[15:0];
                    4'hD:             result_d = src;
                    4'hE:             result_d = mul_s;
                    default:          result_d = sum_s[15:0];
                endcase
            end
            OP_ANDI: result_d = dst & src;
            OP_ORI:  result_d = dst | src;
            OP_XORI: result_d = dst ^ src;
            OP_SPEC: begin
                case (func)
                    4'h8:    result_d = src;
                    4'hC:    result_d = taken_s ? src : dst;
                    4'hD:    result_d = {15'h0000, taken_s};
                    default: result_d = sum_s[15:0];
                endcase
            end
            OP_ADDI, OP_ADDUI, OP_ADDCI: result_d = sum_s[15:0];
            OP_SHIFT:                    result_d = shift_res_s;
            OP_SUBI, OP_SUBCI, OP_CMPI:  result_d = diff_s[15:0];
            OP_BCOND: result_d = taken_s ? sum_s[15:0] : dst;
            OP_MOVI:  result_d = src;
            OP_MULI:  result_d = mul_s;
            OP_LUI:   result_d = {src[7:0], dst[7:0]};
            default:  result_d = 16'h0000;
        endcase
    end

    // Flag generation; flags not owned by the operation stay zero
    always_comb begin
        wr_s = logic_wr_s | add_fl_s | sub_fl_s | cmp_s;
        if (add_fl_s) begin
            c_s = sum_s[16];
            f_s = add_ovf_s;
        end else if (sub_fl_s) begin
            c_s = diff_s[16];
            f_s = sub_ovf_s;
        end else begin
            c_s = 1'b0;
            f_s = 1'b0;
        end
        l_s        = cmp_s ? (dst < src) : 1'b0;
        z_s        = wr_s ? (result_d == 16'h0000) : 1'b0;
        n_s        = (add_fl_s | sub_fl_s | cmp_s) ? result_d[15] : 1'b0;
        cond_out_d = {c_s, l_s, f_s, z_s, n_s};
        cond_wr_d  = wr_s;
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= 16'h0000;
            cond_out_q <= 5'b00000;
            cond_wr_q  <= 1'b0;
        end else begin
            result_q   <= result_d;
            cond_out_q <= cond_out_d;
            cond_wr_q  <= cond_wr_d;
        end
    end

    assign result  = result_q;
    assign condOut = cond_out_q;
    assign condWr  = cond_wr_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed scoreboard bench for alu_unit: expectations queued at drive time, checked one edge later.
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [15:0] dst, src;
    logic [3:0]  oper, func, cond;
    logic [4:0]  condIn;
    logic [15:0] result;
    logic [4:0]  condOut;
    logic        condWr;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [4:0]  flg;
        logic        wr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .dst    (dst),
        .src    (src),
        .oper   (oper),
        .func   (func),
        .cond   (cond),
        .condIn (condIn),
        .result (result),
        .condOut(condOut),
        .condWr (condWr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [3:0] op, input logic [3:0] fn,
                        input logic [3:0] cc, input logic [4:0] ci,
                        input logic [15:0] d, input logic [15:0] s,
                        input logic [15:0] er, input logic [4:0] ef, input logic ew,
                        input string tag);
        exp_t e;
        reset  = rst;
        oper   = op;
        func   = fn;
        cond   = cc;
        condIn = ci;
        dst    = d;
        src    = s;
        e.tag  = tag;
        e.res  = er;
        e.flg  = ef;
        e.wr   = ew;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (result === e.res) else begin
                errors++;
                $error("FAIL %s result got %h expected %h", e.tag, result, e.res);
            end
            checks++;
            assert (condOut === e.flg) else begin
                errors++;
                $error("FAIL %s condOut got %b expected %b", e.tag, condOut, e.flg);
            end
            checks++;
            assert (condWr === e.wr) else begin
                errors++;
                $error("FAIL %s condWr got %b expected %b", e.tag, condWr, e.wr);
            end
        end else begin
            errors++;
        end
    endtask

    initial begin
        logic [15:0] mul_exp;
`ifdef ALU_MUL_EN
        mul_exp = 16'h000F;
`else
        mul_exp = 16'h0000;
`endif
        reset = 1'b1; oper = 4'h0; func = 4'h0; cond = 4'h0; condIn = 5'b00000;
        dst = 16'h0000; src = 16'h0000;
        @(posedge clk);
        #1;
        // args: rst oper func cond condIn dst src | result condOut condWr
        step(1'b1, 4'h0, 4'h5, 4'h0, 5'b11111, 16'h1234, 16'h4321, 16'h0000, 5'b00000, 1'b0, "reset");
        step(1'b0, 4'h0, 4'h5, 4'h0, 5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 1'b1, "add_wrap");
        step(1'b0, 4'hB, 4'h0, 4'h0, 5'b00000, 16'h0003, 16'h0005, 16'hFFFE, 5'b01001, 1'b1, "cmpi");
        step(1'b0, 4'h0, 4'h7, 4'h0, 5'b10000, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1'b1, "addc_cin");
        step(1'b0, 4'h0, 4'h6, 4'h0, 5'b10000, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 1'b0, "addu");
        step(1'b0, 4'h8, 4'h4, 4'h0, 5'b00000, 16'h8001, 16'hFFFD, 16'h1000, 5'b00000, 1'b0, "lsh_right");
        step(1'b0, 4'h8, 4'h3, 4'h0, 5'b00000, 16'h8000, 16'h001C, 16'hF800, 5'b00000, 1'b0, "ash_right");
        step(1'b0, 4'h8, 4'h0, 4'h0, 5'b00000, 16'h0001, 16'h0004, 16'h0010, 5'b00000, 1'b0, "lsh_left");
        step(1'b0, 4'h8, 4'h1, 4'h0, 5'b00000, 16'hFFFF, 16'h0010, 16'h0000, 5'b00000, 1'b0, "lsr_16");
        step(1'b0, 4'h8, 4'h3, 4'h0, 5'b00000, 16'h8000, 16'h0010, 16'hFFFF, 5'b00000, 1'b0, "asr_16");
        step(1'b0, 4'h8, 4'h6, 4'h0, 5'b00000, 16'h0003, 16'h0002, 16'h000C, 5'b00000, 1'b0, "ashu_left");
        step(1'b0, 4'hC, 4'h0, 4'h0, 5'b00010, 16'h0100, 16'h0010, 16'h0110, 5'b00000, 1'b0, "bcond_taken");
        step(1'b0, 4'hC, 4'h0, 4'h0, 5'b00000, 16'h0100, 16'h0010, 16'h0100, 5'b00000, 1'b0, "bcond_not");
        step(1'b0, 4'h4, 4'hD, 4'hE, 5'b00000, 16'h0100, 16'h0010, 16'h0001, 5'b00000, 1'b0, "scond_uc");
        step(1'b0, 4'h4, 4'hD, 4'hF, 5'b11111, 16'h0100, 16'h0010, 16'h0000, 5'b00000, 1'b0, "scond_never");
        step(1'b0, 4'h4, 4'hD, 4'hA, 5'b00000, 16'h0000, 16'h0000, 16'h0001, 5'b00000, 1'b0, "scond_lo");
        step(1'b0, 4'h0, 4'h9, 4'h0, 5'b00000, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 1'b1, "sub_ovf");
        step(1'b0, 4'h9, 4'h0, 4'h0, 5'b00000, 16'h0001, 16'h0002, 16'hFFFF, 5'b10001, 1'b1, "subi_borrow");
        step(1'b0, 4'h5, 4'h0, 4'h0, 5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b1, "addi_ovf");
        step(1'b0, 4'h3, 4'h0, 4'h0, 5'b00000, 16'h00FF, 16'h00FF, 16'h0000, 5'b00010, 1'b1, "xori_zero");
        step(1'b0, 4'h0, 4'h4, 4'h0, 5'b00000, 16'hFFFF, 16'h0000, 16'h0000, 5'b00010, 1'b1, "not");
        step(1'b0, 4'h0, 4'hF, 4'h0, 5'b00000, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 1'b1, "test");
        step(1'b0, 4'hD, 4'h0, 4'h0, 5'b00000, 16'hAAAA, 16'h1234, 16'h1234, 5'b00000, 1'b0, "movi");
        step(1'b0, 4'hE, 4'h0, 4'h0, 5'b00000, 16'h0003, 16'h0005, mul_exp,  5'b00000, 1'b0, "muli");
        step(1'b0, 4'h4, 4'hC, 4'h1, 5'b00010, 16'h0100, 16'h0200, 16'h0100, 5'b00000, 1'b0, "jcond_not");
        step(1'b0, 4'h4, 4'h8, 4'h0, 5'b00000, 16'h0100, 16'h0200, 16'h0200, 5'b00000, 1'b0, "jal");
        step(1'b0, 4'h4, 4'h0, 4'h0, 5'b00000, 16'h0100, 16'h0200, 16'h0300, 5'b00000, 1'b0, "load_addr");
        step(1'b0, 4'hA, 4'h0, 4'h0, 5'b10000, 16'h0005, 16'h0002, 16'h0002, 5'b00000, 1'b1, "subci_cin");
        step(1'b0, 4'hF, 4'h0, 4'h0, 5'b00000, 16'h12AB, 16'h0034, 16'h34AB, 5'b00000, 1'b0, "lui");
        step(1'b1, 4'h0, 4'h5, 4'h0, 5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 5'b00000, 1'b0, "reset_mid");
        step(1'b0, 4'hF, 4'h0, 4'h0, 5'b00000, 16'h12AB, 16'h0034, 16'h34AB, 5'b00000, 1'b0, "lui_resume");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
